// File: rtl/mod_counter.sv
// ============================================================================
// Module   : mod_counter
// Brief    : Modulo up/down counter with runtime limit and wrap/saturate/one-shot modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               en_i,
    input  logic               up_i,
    input  logic [1:0]         mode_i,
    input  logic [width_p-1:0] limit_i,
    output logic [width_p-1:0] count_o,
    output logic               wrap_o,
    output logic               done_o,
    output logic               tc_o
);

    localparam logic [1:0] c_MODE_SAT  = 2'b01;
    localparam logic [1:0] c_MODE_ONCE = 2'b10;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [width_p-1:0] r_count;
    logic [width_p-1:0] w_count_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic               w_is_wrap;
    logic               w_is_sat;

    // Mode 11 is deliberately folded into wrap.
    assign w_is_sat  = (mode_i == c_MODE_SAT);
    assign w_is_wrap = (mode_i != c_MODE_SAT) && (mode_i != c_MODE_ONCE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (clear_i) begin
            w_state_nxt = S_RUN;
            w_count_nxt = '0;
        end else if (load_i) begin
            w_state_nxt = S_RUN;
            w_count_nxt = (load_val_i > limit_i) ? limit_i : load_val_i;
        end else if (en_i && (r_state == S_RUN)) begin
            if (up_i) begin
                if (r_count >= limit_i) begin
                    if (w_is_wrap) begin
                        w_count_nxt = '0;
                        w_wrap_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = limit_i;
                        if (!w_is_sat) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end else begin
                // A limit lowered below the count snaps back silently.
                if (r_count > limit_i) begin
                    w_count_nxt = limit_i;
                end else if (r_count == '0) begin
                    if (w_is_wrap) begin
                        w_count_nxt = limit_i;
                        w_wrap_nxt  = 1'b1;
                    end else if (!w_is_sat) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
        end
    end

    assign count_o = r_count;
    assign wrap_o  = r_wrap;
    assign done_o  = (r_state == S_DONE);
    assign tc_o    = up_i ? (r_count >= limit_i) : (r_count == '0);

endmodule

`default_nettype wire
